fft_out_buffer: RTL

FFT_OUT_BUFFER -- requirements
Module: fft_out_buffer

---
 rtl/fft_out_buffer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/fft_out_buffer.sv
// fft_out_buffer: ping-pong frame buffer between an FFT core and a ready/valid consumer.
// Ports:
//   clk, rstn               clock, asynchronous active-low reset
//   i_flush                 synchronous abort of partial input frame and both banks
//   i_in_valid, i_in_re/im  input beat (LANES complex samples), no backpressure
//   o_out_valid, i_out_ready, o_out_re/im, o_out_beat, o_out_last  output beat stream
//   o_drop_pulse, o_drop_cnt  dropped-frame pulse and saturating count
// Macro FFT_OBUF_BITREV_EN: read beats in bit-reversed address order.
module fft_out_buffer #(
    parameter int W      = 13,
    parameter int LANES  = 16,
    parameter int NBEATS = 32
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                i_flush,
    input  logic                                i_in_valid,
    input  logic [LANES-1:0][W-1:0]             i_in_re,
    input  logic [LANES-1:0][W-1:0]             i_in_im,
    output logic                                o_out_valid,
    input  logic                                i_out_ready,
    output logic [LANES-1:0][W-1:0]             o_out_re,
    output logic [LANES-1:0][W-1:0]             o_out_im,
    output logic [$clog2(NBEATS)-1:0]           o_out_beat,
    output logic                                o_out_last,
    output logic                                o_drop_pulse,
    output logic [15:0]                         o_drop_cnt
);
    localparam int BW = $clog2(NBEATS);
    localparam logic [BW-1:0] LAST = BW'(NBEATS - 1);

    typedef enum logic [1:0] {WR_IDLE, WR_FILL, WR_DROP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_SEND} rd_state_t;

    logic [LANES-1:0][W-1:0] r_mem_re [2][NBEATS];
    logic [LANES-1:0][W-1:0] r_mem_im [2][NBEATS];

    wr_state_t r_wr_state, w_wr_state_nx;
    rd_state_t r_rd_state, w_rd_state_nx;
    logic [BW-1:0] r_wr_cnt, w_wr_cnt_nx, r_out_beat, w_beat_nx, w_rd_addr;
    logic r_wr_bank, w_wr_bank_nx, r_rd_bank, w_rd_bank_nx;
    logic [1:0] r_full, w_set_mask, w_clr_mask;
    logic w_we, w_set_full, w_drop, w_load, w_clr_full, w_valid_nx;
    logic r_out_valid, r_drop_pulse;
    logic [LANES-1:0][W-1:0] r_out_re, r_out_im;
    logic [15:0] r_drop_cnt;

    // Write side: the beat counter is zero in WR_IDLE, so r_wr_cnt is the store address everywhere.
    always_comb begin
        w_wr_state_nx = r_wr_state;
        w_wr_cnt_nx   = r_wr_cnt;
        w_wr_bank_nx  = r_wr_bank;
        w_we          = 1'b0;
        w_set_full    = 1'b0;
        w_drop        = 1'b0;
        case (r_wr_state)
            WR_IDLE: if (i_in_valid) begin
                w_wr_cnt_nx = BW'(1);
                w_we = !r_full[r_wr_bank];
                w_wr_state_nx = r_full[r_wr_bank] ? WR_DROP : WR_FILL;
            end
            WR_FILL: if (i_in_valid) begin
                w_we = 1'b1;
                w_set_full = (r_wr_cnt == LAST);
                w_wr_bank_nx = w_set_full ? ~r_wr_bank : r_wr_bank;
                w_wr_cnt_nx = w_set_full ? '0 : r_wr_cnt + 1'b1;
                w_wr_state_nx = w_set_full ? WR_IDLE : WR_FILL;
            end
            WR_DROP: if (i_in_valid) begin
                w_drop = (r_wr_cnt == LAST);
                w_wr_cnt_nx = w_drop ? '0 : r_wr_cnt + 1'b1;
                w_wr_state_nx = w_drop ? WR_IDLE : WR_DROP;
            end
            default: ;
        endcase
    end

    // Read side: in RD_SEND out_valid is always high, so i_out_ready alone means accept.
    always_comb begin
        w_rd_state_nx = r_rd_state;
        w_rd_bank_nx  = r_rd_bank;
        w_beat_nx     = r_out_beat;
        w_valid_nx    = r_out_valid;
        w_load        = 1'b0;
        w_clr_full    = 1'b0;
        case (r_rd_state)
            RD_IDLE: if (r_full[r_rd_bank]) begin
                w_load = 1'b1;
                w_beat_nx = '0;
                w_valid_nx = 1'b1;
                w_rd_state_nx = RD_SEND;
            end
            RD_SEND: if (i_out_ready) begin
                if (r_out_beat == LAST) begin
                    w_clr_full = 1'b1;
                    w_rd_bank_nx = ~r_rd_bank;
                    w_load = r_full[~r_rd_bank];
                    w_beat_nx = '0;
                    w_valid_nx = r_full[~r_rd_bank];
                    w_rd_state_nx = r_full[~r_rd_bank] ? RD_SEND : RD_IDLE;
                end else begin
                    w_load = 1'b1;
                    w_beat_nx = r_out_beat + 1'b1;
                end
            end
            default: ;
        endcase
    end

`ifdef FFT_OBUF_BITREV_EN
    always_comb begin
        w_rd_addr = '0;
        for (int k = 0; k < BW; k++) w_rd_addr[k] = w_beat_nx[BW-1-k];
    end
`else
    assign w_rd_addr = w_beat_nx;
`endif

    assign w_set_mask = {2{w_set_full}} & (r_wr_bank ? 2'b10 : 2'b01);
    assign w_clr_mask = {2{w_clr_full}} & (r_rd_bank ? 2'b10 : 2'b01);

    always_ff @(posedge clk) begin
        if (w_we && !i_flush) begin
            r_mem_re[r_wr_bank][r_wr_cnt] <= i_in_re;
            r_mem_im[r_wr_bank][r_wr_cnt] <= i_in_im;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_state   <= WR_IDLE;
            r_rd_state   <= RD_IDLE;
            r_wr_cnt     <= '0;
            r_wr_bank    <= 1'b0;
            r_rd_bank    <= 1'b0;
            r_full       <= '0;
            r_out_valid  <= 1'b0;
            r_out_beat   <= '0;
            r_out_re     <= '0;
            r_out_im     <= '0;
            r_drop_pulse <= 1'b0;
            r_drop_cnt   <= '0;
        end else if (i_flush) begin
            // Bank selects realign to 0 so the next frame is written and read from the same bank.
            r_wr_state   <= WR_IDLE;
            r_rd_state   <= RD_IDLE;
            r_wr_cnt     <= '0;
            r_wr_bank    <= 1'b0;
            r_rd_bank    <= 1'b0;
            r_full       <= '0;
            r_out_valid  <= 1'b0;
            r_out_beat   <= '0;
            r_drop_pulse <= 1'b0;
        end else begin
            r_wr_state   <= w_wr_state_nx;
            r_rd_state   <= w_rd_state_nx;
            r_wr_cnt     <= w_wr_cnt_nx;
            r_wr_bank    <= w_wr_bank_nx;
            r_rd_bank    <= w_rd_bank_nx;
            r_full       <= (r_full | w_set_mask) & ~w_clr_mask;
            r_out_valid  <= w_valid_nx;
            r_out_beat   <= w_beat_nx;
            r_drop_pulse <= w_drop;
            if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
            if (w_load) begin
                r_out_re <= r_mem_re[w_rd_bank_nx][w_rd_addr];
                r_out_im <= r_mem_im[w_rd_bank_nx][w_rd_addr];
            end
        end
    end

    assign o_out_valid  = r_out_valid;
    assign o_out_re     = r_out_re;
    assign o_out_im     = r_out_im;
    assign o_out_beat   = r_out_beat;
    assign o_out_last   = r_out_valid && (r_out_beat == LAST);
    assign o_drop_pulse = r_drop_pulse;
    assign o_drop_cnt   = r_drop_cnt;
endmodule
